// File: rtl/simple_cpu_pkg.sv
// Shared constants and state encoding for the simple_processor program feeder.
package simple_cpu_pkg;

  localparam int INSTR_W = 23;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/program_sequencer_if.sv
// Host-load / processor-issue bundle between program_sequencer and its neighbours.
interface program_sequencer_if #(
  parameter int INSTR_W = simple_cpu_pkg::INSTR_W,
  parameter int ADDR_W  = simple_cpu_pkg::ADDR_W
);

  logic               load_valid;
  logic [INSTR_W-1:0] load_data;
  logic               load_ready;
  logic               clear;
  logic               go;
  logic               proc_ack;
  logic [INSTR_W-1:0] program_out;
  logic               proc_start;
  logic               busy;
  logic               done;
  logic               error;
  logic [ADDR_W:0]    count;

  modport master (
    output load_valid, load_data, clear, go, proc_ack,
    input  load_ready, program_out, proc_start, busy, done, error, count
  );

  modport slave (
    input  load_valid, load_data, clear, go, proc_ack,
    output load_ready, program_out, proc_start, busy, done, error, count
  );

endinterface

// File: rtl/prog_buffer.sv
// Program storage: one synchronous write port, one combinational read port.
module prog_buffer #(
  parameter int INSTR_W = 23,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [INSTR_W-1:0] rd_data
);

  logic [INSTR_W-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/program_sequencer.sv
// Buffers a host-written program and hands it to simple_processor one
// instruction at a time, pacing on the processor's write pulse.
module program_sequencer #(
  parameter int INSTR_W = simple_cpu_pkg::INSTR_W,
  parameter int DEPTH   = simple_cpu_pkg::DEPTH,
  parameter int ADDR_W  = simple_cpu_pkg::ADDR_W,
  parameter int TIMEOUT = simple_cpu_pkg::TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  program_sequencer_if.slave  bus
);

  import simple_cpu_pkg::*;

  localparam logic [7:0]      TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_CNT   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_PTR = ADDR_W'(1);

  seq_state_t         state_reg, state_next;
  logic [ADDR_W:0]    count_reg, count_next;
  logic [ADDR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [7:0]         wdog_reg, wdog_next;
  logic               error_reg, error_next;
  logic [INSTR_W-1:0] program_out_reg, program_out_next;

  logic               load_ready;
  logic               wr_en;
  logic               last_word;
  logic               timeout_hit;
  logic [ADDR_W-1:0]  rd_addr;
  logic [INSTR_W-1:0] rd_data;

  assign load_ready  = (state_reg == ST_IDLE) && (count_reg < DEPTH_C) && !bus.clear;
  // go outranks a same-cycle load, so the write is suppressed even when ready
  assign wr_en       = bus.load_valid && load_ready && !bus.go;
  assign last_word   = ({1'b0, rd_ptr_reg} == (count_reg - ONE_CNT));
  assign timeout_hit = ((wdog_reg + 8'd1) == TIMEOUT_C);
  // IDLE fetches entry 0 for the first issue; WAIT prefetches the next entry
  assign rd_addr     = (state_reg == ST_IDLE) ? '0 : (rd_ptr_reg + ONE_PTR);

  prog_buffer #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (count_reg[ADDR_W-1:0]),
    .wr_data (bus.load_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      count_reg       <= '0;
      rd_ptr_reg      <= '0;
      wdog_reg        <= '0;
      error_reg       <= 1'b0;
      program_out_reg <= '0;
    end else begin
      state_reg       <= state_next;
      count_reg       <= count_next;
      rd_ptr_reg      <= rd_ptr_next;
      wdog_reg        <= wdog_next;
      error_reg       <= error_next;
      program_out_reg <= program_out_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    count_next       = count_reg;
    rd_ptr_next      = rd_ptr_reg;
    wdog_next        = wdog_reg;
    error_next       = error_reg;
    program_out_next = program_out_reg;

    case (state_reg)
      ST_IDLE: begin
        if (bus.clear) begin
          count_next = '0;
          error_next = 1'b0;
        end else if (bus.go) begin
          if (count_reg != '0) begin
            rd_ptr_next      = '0;
            program_out_next = rd_data;
            state_next       = ST_ISSUE;
          end else begin
            state_next = ST_DONE;
          end
        end else if (wr_en) begin
          count_next = count_reg + ONE_CNT;
        end
      end

      ST_ISSUE: begin
        wdog_next  = '0;
        state_next = ST_WAIT;
      end

      ST_WAIT: begin
        wdog_next = wdog_reg + 8'd1;
        if (bus.proc_ack) begin
          if (last_word) begin
            state_next = ST_DONE;
          end else begin
            rd_ptr_next      = rd_ptr_reg + ONE_PTR;
            program_out_next = rd_data;
            state_next       = ST_ISSUE;
          end
        end else if (timeout_hit) begin
          error_next = 1'b1;
          state_next = ST_DONE;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.load_ready  = load_ready;
  assign bus.program_out = program_out_reg;
  // decoded straight from the state register so reset drops it asynchronously
  assign bus.proc_start  = (state_reg == ST_ISSUE);
  assign bus.busy        = (state_reg != ST_IDLE);
  assign bus.done        = (state_reg == ST_DONE);
  assign bus.error       = error_reg;
  assign bus.count       = count_reg;

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: host loads, a model processor acks,
// issued words are popped from the expected queue as proc_start appears.
module tb_program_sequencer;

  localparam int IW = simple_cpu_pkg::INSTR_W;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  program_sequencer_if #(.INSTR_W(IW), .ADDR_W(AW)) bus ();

  program_sequencer #(
    .INSTR_W (IW),
    .DEPTH   (16),
    .ADDR_W  (AW),
    .TIMEOUT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int starts      = 0;
  int done_cnt    = 0;
  int done_cyc    = 0;
  bit ack_en      = 1'b1;
  bit saw_start   = 1'b0;

  logic [IW-1:0] sb_q[$];
  logic [IW-1:0] model_mem[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %-14s got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %-14s 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output side: every proc_start cycle must match the head of the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (bus.proc_start === 1'b1) begin
        starts++;
        check("start_pending", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          check("program_out", 32'(bus.program_out), 32'(sb_q.pop_front()));
        end
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Model processor: pulses write in the cycle right after each start
  initial begin
    bus.proc_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.proc_ack = ack_en && saw_start;
      saw_start    = (bus.proc_start === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout sim did not finish");
    $fatal(1);
  end

  task automatic load_word(input logic [IW-1:0] w);
    bus.load_valid = 1'b1;
    bus.load_data  = w;
    if (model_mem.size() < 16) model_mem.push_back(w);
    $display("load 0x%06h", w);
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    model_mem.delete();
    $display("clear");
  endtask

  // Issue go, expect the first n_issue stored words, then a single done pulse
  task automatic run_go(input int n_issue, input bit timely);
    int d0;
    int s0;
    int g;
    d0 = done_cnt;
    s0 = starts;
    for (int i = 0; i < n_issue; i++) sb_q.push_back(model_mem[i]);
    $display("go expecting %0d issues", n_issue);
    bus.go = 1'b1;
    tick();
    g = cyc;
    bus.go = 1'b0;
    check("busy_after_go", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 200 && done_cnt == d0; i++) tick();
    tick();
    tick();
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
    if (timely) check("done_cycle", 32'(done_cyc - g), 32'(2 * n_issue));
    check("issue_count", 32'(starts - s0), 32'(n_issue));
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("busy_end", 32'(bus.busy), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    reset          = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.clear      = 1'b0;
    bus.go         = 1'b0;
    tick();
    tick();
    check("rst_start", 32'(bus.proc_start), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_error", 32'(bus.error), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_prog_out", 32'(bus.program_out), 32'd0);
    check("rst_ready", 32'(bus.load_ready), 32'd1);
    reset = 1'b0;
    tick();

    // three-word program, then replay it
    load_word(23'h000001);
    load_word(23'h7FFFFF);
    load_word(23'h123456);
    check("count_3", 32'(bus.count), 32'd3);
    run_go(3, 1'b1);
    check("err_after_run", 32'(bus.error), 32'd0);
    run_go(3, 1'b1);
    check("prog_out_held", 32'(bus.program_out), 32'h123456);

    // fill past capacity with load_valid held
    do_clear();
    bus.load_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.load_data = IW'(32'h100 + i * 32'h1111);
      if (model_mem.size() < 16) model_mem.push_back(bus.load_data);
      $display("load 0x%06h", bus.load_data);
      tick();
      if (i == 15) check("ready_full", 32'(bus.load_ready), 32'd0);
    end
    bus.load_valid = 1'b0;
    check("count_full", 32'(bus.count), 32'd16);
    run_go(16, 1'b1);
    do_clear();
    check("count_cleared", 32'(bus.count), 32'd0);

    // empty program
    run_go(0, 1'b1);

    // hung processor: first word issues, watchdog fires, rest skipped
    load_word(23'h0000AA);
    load_word(23'h0000BB);
    load_word(23'h0000CC);
    ack_en = 1'b0;
    run_go(1, 1'b0);
    check("hung_error", 32'(bus.error), 32'd1);
    tick();
    check("error_sticky", 32'(bus.error), 32'd1);
    check("hung_count", 32'(bus.count), 32'd3);
    do_clear();
    check("error_cleared", 32'(bus.error), 32'd0);
    ack_en = 1'b1;

    // reset asserted while waiting for an ack
    load_word(23'h055555);
    load_word(23'h02AAAA);
    load_word(23'h011111);
    ack_en = 1'b0;
    sb_q.push_back(model_mem[0]);
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("mid_rst_start", 32'(bus.proc_start), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_count", 32'(bus.count), 32'd0);
    check("mid_rst_sb", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    model_mem.delete();
    tick();
    tick();
    reset  = 1'b0;
    ack_en = 1'b1;
    tick();
    check("post_rst_ready", 32'(bus.load_ready), 32'd1);
    load_word(23'h3C3C3C);
    load_word(23'h0F0F0F);
    run_go(2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
